// File: rtl/quarter_wave_gen.sv
// Quarter-cycle triangle datapath: a prescaler, a magnitude counter and a registered signed sample.
// When QWG_SQUARE_EN is defined, the sq_sel input selects a full-scale square wave instead.
module quarter_wave_gen #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] freq,
  input  logic             phase,
  input  logic             sign,
`ifdef QWG_SQUARE_EN
  input  logic             sq_sel,
`endif
  output logic             tick,
  output logic             co,
  output logic [WIDTH:0]   wave
);

  localparam logic [WIDTH-1:0] MAX = '1;

  logic [DIV_W-1:0] pre;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] mag;
  logic [WIDTH:0]   mag_ext;
  logic [WIDTH:0]   sample;

  // A >= compare lets a lowered reload take effect at once, with no wrap-around stall.
  assign tick    = rst & en & (pre >= freq);
  assign co      = tick & (cnt == MAX);
  assign mag     = phase ? (MAX - cnt) : cnt;
  assign mag_ext = {1'b0, mag};

  always_comb begin
    sample = sign ? -mag_ext : mag_ext;
`ifdef QWG_SQUARE_EN
    if (sq_sel) sample = sign ? -{1'b0, MAX} : {1'b0, MAX};
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      pre <= '0;
    else if (tick) pre <= '0;
    else if (en)   pre <= pre + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cnt <= '0;
    else if (tick) cnt <= cnt + 1'b1;
  end

  // The sample register updates every clock, so phase and sign changes show up even while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wave <= '0;
    else      wave <= sample;
  end

endmodule

// File: tb/tb_quarter_wave_gen.sv
// Directed bench for quarter_wave_gen (WIDTH=4), with a behavioural 4-state quadrant controller attached.
module tb_quarter_wave_gen;
  localparam int W = 4;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic [D-1:0] freq = '0;
  logic         tick, co;
  logic [W:0]   wave;
  logic [1:0]   quad;
  logic         phase, sign;
`ifdef QWG_SQUARE_EN
  logic         sq_sel = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         en;
    logic [D-1:0] freq;
    logic         tick;
    logic         co;
    int           wave;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  quarter_wave_gen #(.WIDTH(W), .DIV_W(D)) dut (
    .clk(clk), .rst(rst), .en(en), .freq(freq), .phase(phase), .sign(sign),
`ifdef QWG_SQUARE_EN
    .sq_sel(sq_sel),
`endif
    .tick(tick), .co(co), .wave(wave)
  );

  // Quadrant controller: A(0) B(1) C(2) D(3), advanced by co.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    quad <= 2'd0;
    else if (co) quad <= quad + 2'd1;
  end
  assign phase = quad[0];
  assign sign  = quad[1];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Ideal sample for the i-th counter state of a period: 0..15, 15..0, 0..-15, -15..0.
  function automatic int seqv(input int i);
    int q, r;
    q = (i / 16) % 4;
    r = i % 16;
    case (q)
      0: seqv = r;
      1: seqv = 15 - r;
      2: seqv = -r;
      default: seqv = -(15 - r);
    endcase
  endfunction

  // Entry j (1-based) covers enabled cycle j after reset release; wave shows cycle j-1's state.
  task automatic fill(input int f, input int n, input bit sq);
    vec_t v;
    tbl.delete();
    for (int j = 1; j <= n; j++) begin
      v.en   = 1'b1;
      v.freq = D'(f);
      v.tick = (j % (f + 1)) == 0;
      v.co   = (j % (16 * (f + 1))) == 0;
      if (j == 1)  v.wave = 0;
      else if (sq) v.wave = ((((j - 2) / (f + 1)) / 32) % 2) ? -15 : 15;
      else         v.wave = seqv((j - 2) / (f + 1));
      tbl.push_back(v);
    end
  endtask

  task automatic run_tbl(input string tag);
    foreach (tbl[j]) begin
      en   = tbl[j].en;
      freq = tbl[j].freq;
      #1;
      chk($sformatf("%s[%0d] tick", tag, j + 1), int'(tick), int'(tbl[j].tick));
      chk($sformatf("%s[%0d] co", tag, j + 1), int'(co), int'(tbl[j].co));
      chk($sformatf("%s[%0d] wave", tag, j + 1), int'($signed(wave)), tbl[j].wave);
      @(negedge clk);
    end
  endtask

  // Leaves the bench 1 ns into enabled cycle 1.
  task automatic reset_dut(input int f);
    @(negedge clk);
    rst  = 1'b0;
    en   = 1'b1;
    freq = D'(f);
    repeat (2) @(negedge clk);
    #1;
    chk("reset wave", int'($signed(wave)), 0);
    chk("reset tick", int'(tick), 0);
    chk("reset co", int'(co), 0);
    rst = 1'b1;
  endtask

  initial begin
    // Full period, tick every clock
    reset_dut(0);
    fill(0, 66, 1'b0);
    run_tbl("f0");

    // Tick every third clock, period 192
    reset_dut(2);
    fill(2, 194, 1'b0);
    run_tbl("f2");

    // Lower the reload below pre mid-count
    reset_dut(5);
    repeat (4) @(negedge clk);
    #1 chk("presc pre4 tick", int'(tick), 0);
    freq = 8'd1;
    #1 chk("presc change tick", int'(tick), 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1 chk($sformatf("presc after[%0d] tick", k), int'(tick), k % 2);
    end
    chk("presc wave", int'($signed(wave)), 2);

    // Enable stall in quadrant B with cnt=7
    reset_dut(0);
    repeat (23) @(negedge clk);
    #1 chk("stall pre wave", int'($signed(wave)), 9);
    en = 1'b0;
    #1 chk("stall tick off", int'(tick), 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("stall[%0d] wave", k), int'($signed(wave)), 8);
      chk($sformatf("stall[%0d] tick", k), int'(tick), 0);
      chk($sformatf("stall[%0d] co", k), int'(co), 0);
    end
    en = 1'b1;
    #1 chk("resume tick", int'(tick), 1);
    @(negedge clk);
    #1 chk("resume wave hold", int'($signed(wave)), 8);
    @(negedge clk);
    #1 chk("resume wave step", int'($signed(wave)), 7);

    // Asynchronous reset in quadrant C
    reset_dut(0);
    repeat (42) @(negedge clk);
    #1 chk("midrst pre wave", int'($signed(wave)), -9);
    #1 rst = 1'b0;
    #1;
    chk("midrst wave", int'($signed(wave)), 0);
    chk("midrst co", int'(co), 0);
    chk("midrst tick", int'(tick), 0);
    chk("midrst quad", int'(quad), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    fill(0, 20, 1'b0);
    run_tbl("restart");

`ifdef QWG_SQUARE_EN
    // Square wave: same co cadence, full-scale samples
    reset_dut(0);
    sq_sel = 1'b1;
    fill(0, 66, 1'b1);
    run_tbl("sq");
    sq_sel = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/quarter_wave_gen.md
Name: quarter_wave_gen

Overview:
- Quarter-cycle datapath for the function generator; sits beside the 4-state quadrant controller.
- Produces the `co` quarter-complete pulse that advances the controller.
- Consumes the controller's `phase` (0 = rising, 1 = falling magnitude) and `sign` (0 = positive, 1 = negative).
- Outputs a signed triangle sample stream; a programmable prescaler sets output frequency.

Parameters:
- WIDTH, 8, magnitude counter width; full scale MAX = 2^WIDTH-1.
- DIV_W, 8, prescaler reload width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  run enable; low freezes prescaler and counter.
- freq  in  DIV_W  prescaler reload; one tick every freq+1 enabled clocks.
- phase  in  1  from controller: 0 = magnitude = cnt, 1 = magnitude = MAX-cnt.
- sign  in  1  from controller: 1 = negate magnitude.
- tick  out  1  combinational step strobe.
- co  out  1  combinational quarter-complete pulse to controller.
- wave  out  WIDTH+1  registered two's-complement sample.

Behaviour:
- Reset (rst=0, async): pre=0, cnt=0, wave=0; tick=0 and co=0 while in reset.
- Prescaler:
  - tick = en && (pre >= freq).
  - On tick, pre<=0; else if en, pre<=pre+1; else hold.
  - `>=` compare: lowering freq below current pre gives a tick on the next enabled cycle, with no wrap-around stall.
- Counter:
  - On tick, cnt<=cnt+1, wrapping MAX->0; else hold.
- co:
  - co = tick && (cnt==MAX); single-cycle Mealy pulse, same cycle as the wrapping tick.
  - The controller registers its next state on that edge, so the new phase/sign are valid in the same cycle cnt becomes 0.
- Magnitude (combinational): mag = phase ? (MAX-cnt) : cnt; WIDTH bits, never overflows.
- Sample:
  - Every clock (not gated by en or tick): wave <= sign ? -{1'b0,mag} : {1'b0,mag}.
  - Range -MAX..+MAX; -0 encodes as 0.
- Latency: wave reflects cnt/phase/sign one clock after they change.
- Quadrant sequence per period, with controller A->B->C->D:
  - A: 0..MAX
  - B: MAX..0
  - C: 0..-MAX
  - D: -MAX..0
  - Peaks and zeros are each held two steps at quadrant seams; this is intended.
- Period = 4*(MAX+1)*(freq+1) enabled clocks.
- en deassert mid-quarter: pre, cnt and wave hold (wave recomputed, unchanged unless phase/sign move); no co.
- Reset mid-operation: all state cleared immediately; the controller, reset by the same net, restarts at quadrant A, so the first sample is 0.

Optional Feature:
- Macro: QWG_SQUARE_EN.
- Defined:
  - Adds input `sq_sel` (1 bit).
  - When sq_sel=1, wave <= sign ? -MAX : +MAX, registered with the same latency.
  - Prescaler, counter and co are unaffected, so the square period equals the triangle period.
  - sq_sel is sampled every clock; switching it mid-period changes only the next sample.
- Undefined:
  - No sq_sel port; triangle only.
  - The RTL must contain no square-wave logic.

Test Plan:
- Bench setup: WIDTH=4, freq=0, en=1, with the controller attached, release rst → tick every clock; co high on clocks 16, 32, 48, 64; wave walks 0..15, 15..0, 0..-15, -15..0; period 64 clocks.
- WIDTH=4, freq=2 → tick every 3rd enabled clock; co every 48 clocks; each wave value held 3 clocks; period 192.
- Prescaler change: freq=5, run until pre=4, then set freq=1 → tick on the next clock; afterwards tick every 2 clocks.
- Enable stall: drop en for 10 clocks with cnt=7 in quadrant B → wave holds +8, no tick/co; resume at +7 on the next tick.
- Reset mid-run: assert rst=0 asynchronously in quadrant C with wave=-9 → wave=0, cnt=0, co=0 before the next clock edge; after release, sequence restarts at quadrant A from 0.
- QWG_SQUARE_EN defined, sq_sel=1, WIDTH=4, freq=0 → wave=+15 for 32 clocks then -15 for 32 clocks; co timing identical to the first scenario.
